// File: rtl/sram_responder.sv
// sram_responder: SRAM-bus responder for the LC-3 datapath.
// Samples active-low CE/OE/WE/UB/LB strobes, gives one-cycle registered
// reads and byte-masked single-commit writes to an on-chip word array.
// Optional feature macro: SRAM_IO_MAP_EN maps word 0xFFFF to SW (read)
// and HEX_out (write). Without it, 0xFFFF is ordinary aliased memory.
module sram_responder #(
    parameter int ADDR_W = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_to_mem,
    input  logic        Mem_CE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] SW,
    output logic [15:0] Data_from_mem,
    output logic        Rd_valid,
    output logic [15:0] HEX_out,
    output logic        Conflict
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, WR_HOLD} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_active;
    logic                w_rd_fire;
    logic                w_wr_fire;
    logic                w_conflict;
    logic                w_io_hit;
    logic [1:0]          w_byte_en;
    logic [1:0]          w_mem_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [15:0]         w_rd_word;
    logic [15:0]         w_rd_src;
    logic [1:0]          r_rd_en;
    logic                r_rd_valid;
    logic                r_conflict;

    assign w_active   = ~Mem_CE;
    assign w_addr     = ADDR[ADDR_W-1:0];
    assign w_byte_en  = {~Mem_UB, ~Mem_LB};
    // A read is only sampled when WE is high: writes win a strobe clash.
    assign w_rd_fire  = w_active & ~Mem_OE & Mem_WE;
    // Only the first WE-low cycle of a pulse commits; WRITE/WR_HOLD never do.
    assign w_wr_fire  = w_active & ~Mem_WE & ((r_state == IDLE) || (r_state == READ));
    assign w_conflict = w_active & ~Mem_OE & ~Mem_WE;

`ifdef SRAM_IO_MAP_EN
    logic        r_rd_io;
    logic [15:0] r_sw_q;
    logic [15:0] r_hex;
    logic        w_unused;

    assign w_io_hit = (ADDR[15:0] == 16'hFFFF);
    assign w_rd_src = r_rd_io ? r_sw_q : w_rd_word;
    assign HEX_out  = r_hex;
    assign w_unused = ^ADDR[19:ADDR_W];

    // Capture the switch value alongside the source select of each read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_io <= 1'b0;
        end else if (w_rd_fire) begin
            r_rd_io <= w_io_hit;
            r_sw_q  <= SW;
        end
    end

    // HEX output register, byte-masked like a memory write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hex <= 16'h0000;
        end else if (w_wr_fire && w_io_hit) begin
            for (int i = 0; i < 2; i++) begin
                if (w_byte_en[i]) begin
                    r_hex[i*8 +: 8] <= Data_to_mem[i*8 +: 8];
                end
            end
        end
    end
`else
    logic w_unused;

    assign w_io_hit = 1'b0;
    assign w_rd_src = w_rd_word;
    assign HEX_out  = 16'h0000;
    assign w_unused = ^{ADDR[19:ADDR_W], SW};
`endif

    // One byte lane per generate block keeps each lane a plain block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] r_mem [0:(2**ADDR_W)-1];
            logic [7:0] r_rd_byte;

            assign w_mem_we[gi] = w_wr_fire & ~Reset & ~w_io_hit & w_byte_en[gi];
            assign w_rd_word[gi*8 +: 8] = r_rd_byte;
            // Reads of a disabled byte lane are forced to zero at the output.
            assign Data_from_mem[gi*8 +: 8] = r_rd_en[gi] ? w_rd_src[gi*8 +: 8] : 8'h00;

            // Lane write and registered read; contents are never reset.
            always_ff @(posedge Clk) begin
                if (w_mem_we[gi]) begin
                    r_mem[w_addr] <= Data_to_mem[gi*8 +: 8];
                end
                if (w_rd_fire) begin
                    r_rd_byte <= r_mem[w_addr];
                end
            end
        end
    endgenerate

    // Read qualifiers and the sticky conflict flag; enables reset to zero
    // so Data_from_mem reads 0x0000 out of reset without clearing the RAM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_en    <= 2'b00;
            r_rd_valid <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_en <= w_byte_en;
            end
            if (w_conflict) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign Rd_valid = r_rd_valid;
    assign Conflict = r_conflict;

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; CE high forces IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        if (!w_active) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!Mem_WE)      w_state_next = WRITE;
                    else if (!Mem_OE) w_state_next = READ;
                    else              w_state_next = IDLE;
                end
                READ: begin
                    if (!Mem_WE)      w_state_next = WRITE;
                    else if (Mem_OE)  w_state_next = IDLE;
                    else              w_state_next = READ;
                end
                WRITE: begin
                    if (!Mem_WE)      w_state_next = WR_HOLD;
                    else              w_state_next = IDLE;
                end
                WR_HOLD: begin
                    if (!Mem_WE)      w_state_next = WR_HOLD;
                    else              w_state_next = IDLE;
                end
                default:              w_state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: directed vector table, hand-written
// multi-cycle sequences and a queue scoreboard for random reads/writes.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [19:0] ADDR;
    logic [15:0] Data_to_mem;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [15:0] SW;
    logic [15:0] Data_from_mem;
    logic        Rd_valid;
    logic [15:0] HEX_out;
    logic        Conflict;

    int errors = 0;
    int checks = 0;

    sram_responder dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ADDR         (ADDR),
        .Data_to_mem  (Data_to_mem),
        .Mem_CE       (Mem_CE),
        .Mem_UB       (Mem_UB),
        .Mem_LB       (Mem_LB),
        .Mem_OE       (Mem_OE),
        .Mem_WE       (Mem_WE),
        .SW           (SW),
        .Data_from_mem(Data_from_mem),
        .Rd_valid     (Rd_valid),
        .HEX_out      (HEX_out),
        .Conflict     (Conflict)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        ce, oe, we, ub, lb;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic        exp_rv;
        logic        chk_d;
        logic [15:0] exp_d;
        logic        exp_cf;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb[$];
    logic [15:0] mdl[16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one bus cycle, then sample 1 time unit after the rising edge.
    task automatic drive(input logic ce, input logic oe, input logic we, input logic ub,
                         input logic lb, input logic [19:0] a, input logic [15:0] d);
        Mem_CE = ce; Mem_OE = oe; Mem_WE = we; Mem_UB = ub; Mem_LB = lb;
        ADDR = a; Data_to_mem = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [19:0] a, input logic [15:0] d);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, d);
    endtask

    task automatic rd(input logic [19:0] a);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, 16'h0000);
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0, 16'h0000);
    endtask

    function automatic vec_t mk(input logic ce, input logic oe, input logic we, input logic ub,
                                input logic lb, input logic [19:0] a, input logic [15:0] d,
                                input logic rv, input logic cd, input logic [15:0] ed,
                                input logic cf);
        vec_t v;
        v.ce = ce; v.oe = oe; v.we = we; v.ub = ub; v.lb = lb;
        v.addr = a; v.wdata = d; v.exp_rv = rv; v.chk_d = cd; v.exp_d = ed; v.exp_cf = cf;
        return v;
    endfunction

    initial begin
        Reset = 1'b1; SW = 16'h0000;
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b1; Mem_LB = 1'b1;
        ADDR = '0; Data_to_mem = '0;
        @(posedge Clk); @(posedge Clk); #1;
        check("reset_data", Data_from_mem, 16'h0000);
        check("reset_rv", Rd_valid, 1'b0);
        check("reset_hex", HEX_out, 16'h0000);
        check("reset_conflict", Conflict, 1'b0);
        Reset = 1'b0;

        //             ce    oe    we    ub    lb    addr      data      rv  chk  exp_d     cf
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00003, 16'h1234, 0, 1, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, 0, 1, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00003, 16'h0000, 1, 1, 16'h1234, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00003, 16'h0000, 1, 1, 16'h1234, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00003, 16'h0000, 0, 1, 16'h1234, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00010, 16'h5555, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00010, 16'hABCD, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h0000, 1, 1, 16'h55CD, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00010, 16'h0000, 1, 1, 16'h5500, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, 0, 1, 16'h5500, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00011, 16'h1111, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00011, 16'h2222, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00011, 16'h2222, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00011, 16'h0000, 1, 1, 16'h1111, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00012, 16'h0042, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00012, 16'h0000, 1, 1, 16'h0042, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00003, 16'h0000, 1, 1, 16'h1234, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00410, 16'h0000, 1, 1, 16'h55CD, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00003, 16'h0000, 0, 1, 16'h55CD, 0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, 0, 1, 16'h55CD, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00020, 16'h0F0F, 0, 1, 16'h55CD, 1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00020, 16'h0000, 1, 1, 16'h0F0F, 1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, 0, 0, 16'h0000, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ce, tbl[i].oe, tbl[i].we, tbl[i].ub, tbl[i].lb, tbl[i].addr, tbl[i].wdata);
            $display("row %0d ce=%b oe=%b we=%b ub=%b lb=%b addr=%h d=%h -> rv=%b dout=%h cf=%b",
                     i, tbl[i].ce, tbl[i].oe, tbl[i].we, tbl[i].ub, tbl[i].lb, tbl[i].addr,
                     tbl[i].wdata, Rd_valid, Data_from_mem, Conflict);
            check($sformatf("row%0d_rv", i), Rd_valid, tbl[i].exp_rv);
            check($sformatf("row%0d_cf", i), Conflict, tbl[i].exp_cf);
            if (tbl[i].chk_d) check($sformatf("row%0d_data", i), Data_from_mem, tbl[i].exp_d);
        end

        // Only Reset clears the sticky conflict flag.
        Reset = 1'b1; idle(); Reset = 1'b0;
        $display("reset pulse -> cf=%b rv=%b dout=%h", Conflict, Rd_valid, Data_from_mem);
        check("conflict_cleared", Conflict, 1'b0);
        check("rst_pulse_data", Data_from_mem, 16'h0000);

        // Reset in the first WE-low cycle must block the commit.
        wr(20'h00004, 16'h7777); idle();
        Reset = 1'b1; wr(20'h00004, 16'h9999);
        $display("reset during write -> rv=%b dout=%h cf=%b hex=%h", Rd_valid, Data_from_mem, Conflict, HEX_out);
        check("rstwr_rv", Rd_valid, 1'b0);
        check("rstwr_data", Data_from_mem, 16'h0000);
        check("rstwr_cf", Conflict, 1'b0);
        check("rstwr_hex", HEX_out, 16'h0000);
        Reset = 1'b0; idle();
        rd(20'h00004);
        $display("read 0x0004 after reset -> rv=%b dout=%h", Rd_valid, Data_from_mem);
        check("rstwr_keep_rv", Rd_valid, 1'b1);
        check("rstwr_keep", Data_from_mem, 16'h7777);
        idle();

        // I/O word at 0xFFFF; it aliases to array word 0x3FF.
        SW = 16'hBEEF;
        wr(20'h003FF, 16'h1357); idle();
`ifdef SRAM_IO_MAP_EN
        rd(20'h0FFFF);
        $display("io read -> dout=%h", Data_from_mem);
        check("io_rd_sw", Data_from_mem, 16'hBEEF);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h0FFFF, 16'h0000);
        check("io_rd_masked", Data_from_mem, 16'h00EF);
        idle();
        wr(20'h0FFFF, 16'h00A5); idle();
        $display("io write -> hex=%h", HEX_out);
        check("io_hex", HEX_out, 16'h00A5);
        rd(20'h003FF);
        check("io_mem_untouched", Data_from_mem, 16'h1357);
`else
        wr(20'h0FFFF, 16'h00A5); idle();
        $display("alias write -> hex=%h", HEX_out);
        check("noio_hex", HEX_out, 16'h0000);
        rd(20'h003FF);
        $display("read 0x3FF -> dout=%h", Data_from_mem);
        check("noio_mem", Data_from_mem, 16'h00A5);
`endif
        idle();

        // Scoreboard phase: random masked writes/reads over words 0x100..0x10F.
        for (int i = 0; i < 16; i++) begin
            mdl[i] = 16'(i * 16'h1111) ^ 16'hA5A5;
            wr(20'h00100 + 20'(i), mdl[i]); idle();
        end
        for (int n = 0; n < 80; n++) begin
            int          op;
            int          a;
            logic        ub, lb;
            logic [15:0] d;
            op = $urandom_range(0, 2);
            a  = $urandom_range(0, 15);
            ub = 1'($urandom_range(0, 1));
            lb = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            if (op == 0) begin
                if (!ub) mdl[a][15:8] = d[15:8];
                if (!lb) mdl[a][7:0]  = d[7:0];
                drive(1'b0, 1'b1, 1'b0, ub, lb, 20'h00100 + 20'(a), d);
                $display("sb %0d write a=%h d=%h ub=%b lb=%b", n, a, d, ub, lb);
                idle();
            end else begin
                sb.push_back({ub ? 8'h00 : mdl[a][15:8], lb ? 8'h00 : mdl[a][7:0]});
                drive(1'b0, 1'b0, 1'b1, ub, lb, 20'h00100 + 20'(a), 16'h0000);
                $display("sb %0d read a=%h ub=%b lb=%b -> rv=%b dout=%h", n, a, ub, lb, Rd_valid, Data_from_mem);
            end
            if (Rd_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_spurious: got Rd_valid=1 expected no pending read");
                end else begin
                    check("sb_read", Data_from_mem, sb.pop_front());
                end
            end
        end
        idle();
        check("sb_drain", 16'(sb.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
